// File: rtl/mips16_pkg.sv
// Shared constants for the 16-bit multi-cycle MIPS sequencer: opcodes, ALU codes, FSM states.
package mips16_pkg;

  localparam int unsigned         WIDTH_DEF     = 16;
  localparam logic [15:0]         HALT_WORD_DEF = 16'hFFFF;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;

  // {ainv, binv, op[1:0]}
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/mips16_ctrl_decode.sv
// Combinational opcode decoder: datapath steering and ALU control for ops 0..7.
module mips16_ctrl_decode
  import mips16_pkg::*;
(
  input  logic [3:0] op,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    reg_dst     = 1'b1;
    alu_src     = 1'b0;
    alu_control = ALU_AND;
    legal       = 1'b1;
    case (op)
      OP_ADD:  alu_control = ALU_ADD;
      OP_SUB:  alu_control = ALU_SUB;
      OP_AND:  alu_control = ALU_AND;
      OP_OR:   alu_control = ALU_OR;
      OP_NOR:  alu_control = ALU_NOR;
      OP_NAND: alu_control = ALU_NAND;
      OP_SLT:  alu_control = ALU_SLT;
      OP_ADDI: begin
        reg_dst     = 1'b0;
        alu_src     = 1'b1;
        alu_control = ALU_ADD;
      end
      default: begin
        reg_dst = 1'b0;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips16_multicycle_seq.sv
// Multi-cycle sequencer: fetch handshake, IR, decode/exec/writeback stepping, halt/illegal tracking.
module mips16_multicycle_seq
  import mips16_pkg::*;
#(
  parameter int unsigned       WIDTH         = WIDTH_DEF,
  parameter logic [WIDTH-1:0]  HALT_WORD     = WIDTH'(HALT_WORD_DEF),
  parameter int unsigned       FETCH_TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] ir,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [3:0]       alu_control,
  output logic             halted,
  output logic             illegal,
  output logic [15:0]      instr_count,
  output logic [2:0]       state
);

  state_t      cur;
  logic [31:0] tcnt;
  logic        dec_reg_dst;
  logic        dec_alu_src;
  logic [3:0]  dec_alu_control;
  logic        dec_legal;

  assign state = cur;

  mips16_ctrl_decode u_decode (
    .op          (ir[WIDTH-1:WIDTH-4]),
    .reg_dst     (dec_reg_dst),
    .alu_src     (dec_alu_src),
    .alu_control (dec_alu_control),
    .legal       (dec_legal)
  );

  // Outputs are registered one state ahead, so each is valid for the whole state it belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur         <= S_IDLE;
      ir          <= '0;
      imem_req    <= 1'b0;
      pc_write    <= 1'b0;
      reg_write   <= 1'b0;
      reg_dst     <= 1'b0;
      alu_src     <= 1'b0;
      alu_control <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
      tcnt        <= '0;
    end else begin
      pc_write  <= 1'b0;
      reg_write <= 1'b0;
      case (cur)
        S_IDLE: begin
          if (start) begin
            imem_req <= 1'b1;
            tcnt     <= '0;
            cur      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            cur      <= S_DECODE;
          end else if (FETCH_TIMEOUT != 0 && tcnt == 32'(FETCH_TIMEOUT - 1)) begin
            imem_req <= 1'b0;
            illegal  <= 1'b1;
            halted   <= 1'b1;
            cur      <= S_HALT;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        S_DECODE: begin
          if (ir == HALT_WORD) begin
            halted <= 1'b1;
            cur    <= S_HALT;
          end else if (dec_legal) begin
            reg_dst     <= dec_reg_dst;
            alu_src     <= dec_alu_src;
            alu_control <= dec_alu_control;
            cur         <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            halted  <= 1'b1;
            cur     <= S_HALT;
          end
        end
        S_EXEC: begin
          pc_write    <= 1'b1;
          reg_write   <= 1'b1;
          instr_count <= instr_count + 16'd1;
          cur         <= S_WB;
        end
        S_WB: begin
          reg_dst     <= 1'b0;
          alu_src     <= 1'b0;
          alu_control <= '0;
          imem_req    <= 1'b1;
          tcnt        <= '0;
          cur         <= S_FETCH;
        end
        S_HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          imem_req    <= 1'b0;
          reg_dst     <= 1'b0;
          alu_src     <= 1'b0;
          alu_control <= '0;
          cur         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
